mjp_game_ctrl: RTL and testbench
================================

MJP_GAME_CTRL -- requirements
Module: mjp_game_ctrl

Interface
REQ-001 Parameter WIN_SCORE, default 3, points needed to win the game; legal range 1..9.
REQ-002 Parameter MAX_ROUNDS, default 15, valid rounds allowed before the game is forced to end; legal range 1..15.
REQ-003 CLK  in  1  clock; all state updates occur on the rising edge.
REQ-004 RST  in  1  reset; synchronous, active-high.
REQ-005 A_VALID  in  1  one-cycle strobe; player A submits a sign.
REQ-006 A_SIGN  in  2  player A sign: 00 ROCK, 01 SCISSORS, 10 PAPER, 11 INVALID.
REQ-007 B_VALID  in  1  one-cycle strobe; player B submits a sign.
REQ-008 B_SIGN  in  2  player B sign, same encoding as A_SIGN.
REQ-009 LDISP  out  13 [0:12]  left hand or result display pattern.
REQ-010 RDISP  out  13 [0:12]  right hand or result display pattern.
REQ-011 SC_LDISP  out  13 [0:12]  A score, shown as a 7-segment digit pattern.
REQ-012 SC_RDISP  out  13 [0:12]  B score, shown as a 7-segment digit pattern.
REQ-013 GAME_OVER  out  1  high while in state OVER.

Function
REQ-014 Hand patterns (bit 0 first):
- ROCK 0011101000111
- SCISSORS 0011101101010
- PAPER 0111111010000
- INVALID 0000000101101
REQ-015 Result patterns, given as LDISP/RDISP:
- DRAW 0000001000000/0000001000000
- A WINS 0000001000000/0000000100100
- B WINS 0000000001001/0000001000000
REQ-016 Digit patterns 0..9:
- 1111110000000, 0110000000000, 1101101000000, 1111001000000, 0110011000000
- 1011011000000, 1011111000000, 1110010000000, 1111111000000, 1111011000000
REQ-017 Capture: at an edge with X_VALID=1 and hold flag x_got=0, latch X_SIGN and set x_got. While x_got=1, further X_VALID strobes are ignored.
REQ-018 Simultaneous A_VALID and B_VALID in one cycle capture both signs at the same edge.
REQ-019 Evaluation fires at the first edge where a_got=b_got=1. At that edge: both flags clear, the FSM updates, LDISP/RDISP show the held signs, and the scores update. Latency is 1 cycle from the second capture edge to the updated outputs.
REQ-020 FSM states:
- NEUTRAL: no attacker.
- A_ATK: A is attacker.
- B_ATK: B is attacker.
- OVER: game finished.
REQ-021 NEUTRAL transitions: equal signs keep NEUTRAL; otherwise the round winner's attack state is entered (rock beats scissors, scissors beats paper, paper beats rock).
REQ-022 A_ATK/B_ATK, equal signs: the attacker's score increments by 1 and the FSM returns to NEUTRAL.
REQ-023 A_ATK/B_ATK, unequal signs: the round winner becomes or stays attacker; no score change.
REQ-024 A round where either held sign is INVALID is void: hand patterns are displayed, FSM state and scores are unchanged, and the round counter does not increment.
REQ-025 Each non-void round increments a 4-bit round counter.
REQ-026 If a score reaches WIN_SCORE at an evaluation edge, the FSM enters OVER at that same edge and LDISP/RDISP show that player's WINS pattern.
REQ-027 If the round counter reaches MAX_ROUNDS with no winner, the FSM enters OVER:
- higher score: that player's WINS pattern;
- equal scores: DRAW.
REQ-028 WIN_SCORE takes priority over MAX_ROUNDS when both occur on the same edge.
REQ-029 In OVER: A_VALID/B_VALID are ignored and all outputs hold until RST.
REQ-030 Scores are 4-bit and never exceed WIN_SCORE, so they never wrap.
REQ-031 All outputs are registered; no combinational path from inputs to outputs.

Reset
REQ-032 At an edge with RST=1:
- state = NEUTRAL
- scores, round counter, a_got, b_got = 0
- LDISP = RDISP = 0000000000000
- SC_LDISP = SC_RDISP = digit-0 pattern
- GAME_OVER = 0
REQ-033 RST overrides any concurrent capture or evaluation, including in OVER and with a partial capture pending.

Structure
REQ-034 Shared package mjp_pkg holds:
- sign encodings;
- the hand, result and digit segment constants;
- the FSM state enumeration.
REQ-035 One sub-module, mjp_seg_digit, maps a 4-bit score to its 13-bit digit pattern; it is instantiated twice.

Verification
REQ-036 A=ROCK, B=SCISSORS together; next round A=ROCK, B=ROCK -> after round 1 state A_ATK and LDISP=ROCK pattern; after round 2 SC_LDISP=digit 1, SC_RDISP=digit 0, state NEUTRAL.
REQ-037 A_VALID alone (PAPER), B_VALID 3 cycles later (ROCK), plus an extra A_VALID (SCISSORS) in between -> evaluation one edge after B's capture; LDISP=PAPER pattern (extra strobe ignored); state A_ATK.
REQ-038 A=INVALID, B=PAPER from NEUTRAL -> LDISP=INVALID pattern, RDISP=PAPER pattern; scores and state unchanged; round counter stays 0.
REQ-039 B scores 3 times with WIN_SCORE=3 -> GAME_OVER=1; LDISP=0000000001001, RDISP=0000001000000, SC_RDISP=digit 3; later strobes change nothing.
REQ-040 MAX_ROUNDS=2 with two NEUTRAL ties -> OVER with DRAW pattern on both hand displays.
REQ-041 RST asserted with a_got=1 and score 2:1 -> next cycle all REQ-032 values; a following B-only strobe does not trigger evaluation.

Source files
------------

// File: rtl/mjp_pkg.sv
// Shared definitions for the hand game controller: sign codes, display
// segment patterns (bit 0 is the leftmost character) and FSM states.
package mjp_pkg;

  localparam logic [1:0] SIGN_ROCK     = 2'b00;
  localparam logic [1:0] SIGN_SCISSORS = 2'b01;
  localparam logic [1:0] SIGN_PAPER    = 2'b10;
  localparam logic [1:0] SIGN_INVALID  = 2'b11;

  localparam logic [0:12] HAND_ROCK     = 13'b0011101000111;
  localparam logic [0:12] HAND_SCISSORS = 13'b0011101101010;
  localparam logic [0:12] HAND_PAPER    = 13'b0111111010000;
  localparam logic [0:12] HAND_INVALID  = 13'b0000000101101;

  localparam logic [0:12] RES_DRAW   = 13'b0000001000000;
  localparam logic [0:12] RES_AWIN_L = 13'b0000001000000;
  localparam logic [0:12] RES_AWIN_R = 13'b0000000100100;
  localparam logic [0:12] RES_BWIN_L = 13'b0000000001001;
  localparam logic [0:12] RES_BWIN_R = 13'b0000001000000;
  localparam logic [0:12] DISP_BLANK = 13'b0000000000000;

  localparam logic [0:12] DIGIT_0 = 13'b1111110000000;
  localparam logic [0:12] DIGIT_1 = 13'b0110000000000;
  localparam logic [0:12] DIGIT_2 = 13'b1101101000000;
  localparam logic [0:12] DIGIT_3 = 13'b1111001000000;
  localparam logic [0:12] DIGIT_4 = 13'b0110011000000;
  localparam logic [0:12] DIGIT_5 = 13'b1011011000000;
  localparam logic [0:12] DIGIT_6 = 13'b1011111000000;
  localparam logic [0:12] DIGIT_7 = 13'b1110010000000;
  localparam logic [0:12] DIGIT_8 = 13'b1111111000000;
  localparam logic [0:12] DIGIT_9 = 13'b1111011000000;

  typedef enum logic [1:0] {
    ST_NEUTRAL = 2'b00,
    ST_A_ATK   = 2'b01,
    ST_B_ATK   = 2'b10,
    ST_OVER    = 2'b11
  } state_t;

  // Segment pattern for a held sign; unknown codes show the invalid hand.
  function automatic logic [0:12] hand_pattern(input logic [1:0] sign);
    logic [0:12] pat;
    case (sign)
      SIGN_ROCK:     pat = HAND_ROCK;
      SIGN_SCISSORS: pat = HAND_SCISSORS;
      SIGN_PAPER:    pat = HAND_PAPER;
      default:       pat = HAND_INVALID;
    endcase
    return pat;
  endfunction

  // True when sign x beats sign y (rock > scissors > paper > rock).
  function automatic logic beats(input logic [1:0] x, input logic [1:0] y);
    return ((x == SIGN_ROCK)     && (y == SIGN_SCISSORS)) ||
           ((x == SIGN_SCISSORS) && (y == SIGN_PAPER))    ||
           ((x == SIGN_PAPER)    && (y == SIGN_ROCK));
  endfunction

endpackage

// File: rtl/mjp_seg_digit.sv
// Maps a 4-bit score to its 7-segment style 13-bit display pattern.
module mjp_seg_digit (
  input  logic [3:0]  value,
  output logic [0:12] seg
);
  import mjp_pkg::*;

  // Digit lookup; scores above 9 cannot occur and show a blank display.
  always_comb begin
    seg = DISP_BLANK;
    case (value)
      4'd0:    seg = DIGIT_0;
      4'd1:    seg = DIGIT_1;
      4'd2:    seg = DIGIT_2;
      4'd3:    seg = DIGIT_3;
      4'd4:    seg = DIGIT_4;
      4'd5:    seg = DIGIT_5;
      4'd6:    seg = DIGIT_6;
      4'd7:    seg = DIGIT_7;
      4'd8:    seg = DIGIT_8;
      4'd9:    seg = DIGIT_9;
      default: seg = DISP_BLANK;
    endcase
  end

endmodule

// File: rtl/mjp_game_ctrl.sv
// Two-player hand game controller: captures one sign per player, evaluates
// the round once both are held, tracks attacker state and scores, and ends
// the game on a winning score or when the round budget runs out.
module mjp_game_ctrl #(
  parameter int WIN_SCORE  = 3,
  parameter int MAX_ROUNDS = 15
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        A_VALID,
  input  logic [1:0]  A_SIGN,
  input  logic        B_VALID,
  input  logic [1:0]  B_SIGN,
  output logic [0:12] LDISP,
  output logic [0:12] RDISP,
  output logic [0:12] SC_LDISP,
  output logic [0:12] SC_RDISP,
  output logic        GAME_OVER
);
  import mjp_pkg::*;

  state_t      state_r, state_s;
  logic        a_got_r, a_got_s, b_got_r, b_got_s;
  logic [1:0]  a_sign_r, a_sign_s, b_sign_r, b_sign_s;
  logic [3:0]  score_a_r, score_a_s, score_b_r, score_b_s;
  logic [3:0]  round_r, round_s;
  logic [0:12] ldisp_r, ldisp_s, rdisp_r, rdisp_s;
  logic [0:12] sc_l_r, sc_r_r, digit_a_s, digit_b_s;
  logic        over_r;
  logic        eval_s, same_s, a_win_s;

  // Digit patterns are derived from the next scores so they update on the
  // same edge as the score registers.
  mjp_seg_digit u_digit_a (.value(score_a_s), .seg(digit_a_s));
  mjp_seg_digit u_digit_b (.value(score_b_s), .seg(digit_b_s));

  // Next-state logic: capture, round evaluation, scoring and game end.
  always_comb begin
    state_s   = state_r;
    a_got_s   = a_got_r;
    b_got_s   = b_got_r;
    a_sign_s  = a_sign_r;
    b_sign_s  = b_sign_r;
    score_a_s = score_a_r;
    score_b_s = score_b_r;
    round_s   = round_r;
    ldisp_s   = ldisp_r;
    rdisp_s   = rdisp_r;
    eval_s    = a_got_r & b_got_r;
    same_s    = (a_sign_r == b_sign_r);
    a_win_s   = beats(a_sign_r, b_sign_r);

    if (state_r == ST_OVER) begin
      state_s = ST_OVER;
    end else if (eval_s) begin
      a_got_s = 1'b0;
      b_got_s = 1'b0;
      ldisp_s = hand_pattern(a_sign_r);
      rdisp_s = hand_pattern(b_sign_r);
      if ((a_sign_r == SIGN_INVALID) || (b_sign_r == SIGN_INVALID)) begin
        state_s = state_r;
      end else begin
        round_s = round_r + 4'd1;
        case (state_r)
          ST_NEUTRAL: begin
            if (same_s)       state_s = ST_NEUTRAL;
            else if (a_win_s) state_s = ST_A_ATK;
            else              state_s = ST_B_ATK;
          end
          ST_A_ATK: begin
            if (same_s) begin
              score_a_s = score_a_r + 4'd1;
              state_s   = ST_NEUTRAL;
            end else if (a_win_s) begin
              state_s = ST_A_ATK;
            end else begin
              state_s = ST_B_ATK;
            end
          end
          ST_B_ATK: begin
            if (same_s) begin
              score_b_s = score_b_r + 4'd1;
              state_s   = ST_NEUTRAL;
            end else if (a_win_s) begin
              state_s = ST_A_ATK;
            end else begin
              state_s = ST_B_ATK;
            end
          end
          default: state_s = ST_NEUTRAL;
        endcase

        // A winning score takes precedence over the round budget.
        if (score_a_s == 4'(WIN_SCORE)) begin
          state_s = ST_OVER;
          ldisp_s = RES_AWIN_L;
          rdisp_s = RES_AWIN_R;
        end else if (score_b_s == 4'(WIN_SCORE)) begin
          state_s = ST_OVER;
          ldisp_s = RES_BWIN_L;
          rdisp_s = RES_BWIN_R;
        end else if (round_s == 4'(MAX_ROUNDS)) begin
          state_s = ST_OVER;
          if (score_a_s > score_b_s) begin
            ldisp_s = RES_AWIN_L;
            rdisp_s = RES_AWIN_R;
          end else if (score_b_s > score_a_s) begin
            ldisp_s = RES_BWIN_L;
            rdisp_s = RES_BWIN_R;
          end else begin
            ldisp_s = RES_DRAW;
            rdisp_s = RES_DRAW;
          end
        end else begin
          ldisp_s = hand_pattern(a_sign_r);
          rdisp_s = hand_pattern(b_sign_r);
        end
      end
    end else begin
      // Capture each player's first strobe; later ones wait for evaluation.
      if (A_VALID && !a_got_r) begin
        a_got_s  = 1'b1;
        a_sign_s = A_SIGN;
      end else begin
        a_got_s  = a_got_r;
      end
      if (B_VALID && !b_got_r) begin
        b_got_s  = 1'b1;
        b_sign_s = B_SIGN;
      end else begin
        b_got_s  = b_got_r;
      end
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r   <= ST_NEUTRAL;
      a_got_r   <= 1'b0;
      b_got_r   <= 1'b0;
      a_sign_r  <= SIGN_ROCK;
      b_sign_r  <= SIGN_ROCK;
      score_a_r <= 4'd0;
      score_b_r <= 4'd0;
      round_r   <= 4'd0;
      ldisp_r   <= DISP_BLANK;
      rdisp_r   <= DISP_BLANK;
      sc_l_r    <= DIGIT_0;
      sc_r_r    <= DIGIT_0;
      over_r    <= 1'b0;
    end else begin
      state_r   <= state_s;
      a_got_r   <= a_got_s;
      b_got_r   <= b_got_s;
      a_sign_r  <= a_sign_s;
      b_sign_r  <= b_sign_s;
      score_a_r <= score_a_s;
      score_b_r <= score_b_s;
      round_r   <= round_s;
      ldisp_r   <= ldisp_s;
      rdisp_r   <= rdisp_s;
      sc_l_r    <= digit_a_s;
      sc_r_r    <= digit_b_s;
      over_r    <= (state_s == ST_OVER);
    end
  end

  assign LDISP     = ldisp_r;
  assign RDISP     = rdisp_r;
  assign SC_LDISP  = sc_l_r;
  assign SC_RDISP  = sc_r_r;
  assign GAME_OVER = over_r;

endmodule

// File: tb/tb_mjp_game_ctrl.sv
// Directed bench for mjp_game_ctrl; expected displays are pushed to a
// scoreboard queue and popped once the DUT has evaluated.
module tb_mjp_game_ctrl;
  import mjp_pkg::*;

  localparam logic [1:0] R = 2'b00, S = 2'b01, P = 2'b10, X = 2'b11;
  localparam logic [0:12] E_ROCK = 13'b0011101000111;
  localparam logic [0:12] E_SCI  = 13'b0011101101010;
  localparam logic [0:12] E_PAP  = 13'b0111111010000;
  localparam logic [0:12] E_INV  = 13'b0000000101101;
  localparam logic [0:12] E_DRAW = 13'b0000001000000;
  localparam logic [0:12] E_BW_L = 13'b0000000001001;
  localparam logic [0:12] E_BW_R = 13'b0000001000000;
  localparam logic [0:12] E_ZERO = 13'b0000000000000;
  localparam logic [0:12] E_D0   = 13'b1111110000000;
  localparam logic [0:12] E_D1   = 13'b0110000000000;
  localparam logic [0:12] E_D2   = 13'b1101101000000;
  localparam logic [0:12] E_D3   = 13'b1111001000000;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        A_VALID = 1'b0, B_VALID = 1'b0;
  logic [1:0]  A_SIGN = 2'b00, B_SIGN = 2'b00;
  logic [0:12] LDISP, RDISP, SC_LDISP, SC_RDISP;
  logic [0:12] LDISP2, RDISP2, SC_LDISP2, SC_RDISP2;
  logic        GAME_OVER, GAME_OVER2;

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct {
    string       tag;
    bit          second;
    logic [0:12] l, r, sl, sr;
    logic        over;
    state_t      st;
  } exp_t;
  exp_t sb[$];

  mjp_game_ctrl dut (
    .CLK(CLK), .RST(RST), .A_VALID(A_VALID), .A_SIGN(A_SIGN),
    .B_VALID(B_VALID), .B_SIGN(B_SIGN), .LDISP(LDISP), .RDISP(RDISP),
    .SC_LDISP(SC_LDISP), .SC_RDISP(SC_RDISP), .GAME_OVER(GAME_OVER)
  );

  mjp_game_ctrl #(.WIN_SCORE(3), .MAX_ROUNDS(2)) dut2 (
    .CLK(CLK), .RST(RST), .A_VALID(A_VALID), .A_SIGN(A_SIGN),
    .B_VALID(B_VALID), .B_SIGN(B_SIGN), .LDISP(LDISP2), .RDISP(RDISP2),
    .SC_LDISP(SC_LDISP2), .SC_RDISP(SC_RDISP2), .GAME_OVER(GAME_OVER2)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic cmp(input string tag, input logic [12:0] obs, input logic [12:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic expect_out(input string tag, input bit second,
                            input logic [0:12] l, input logic [0:12] r,
                            input logic [0:12] sl, input logic [0:12] sr,
                            input logic over, input state_t st);
    exp_t e;
    e.tag = tag; e.second = second; e.l = l; e.r = r;
    e.sl = sl; e.sr = sr; e.over = over; e.st = st;
    sb.push_back(e);
  endtask

  task automatic check_out();
    exp_t e;
    if (sb.size() == 0) begin
      cmp("scoreboard_empty", 13'd0, 13'd1);
    end else begin
      e = sb.pop_front();
      if (e.second) begin
        cmp({e.tag, ".ldisp2"}, LDISP2, e.l);
        cmp({e.tag, ".rdisp2"}, RDISP2, e.r);
        cmp({e.tag, ".scl2"}, SC_LDISP2, e.sl);
        cmp({e.tag, ".scr2"}, SC_RDISP2, e.sr);
        cmp({e.tag, ".over2"}, {12'd0, GAME_OVER2}, {12'd0, e.over});
        cmp({e.tag, ".state2"}, {11'd0, dut2.state_r}, {11'd0, e.st});
      end else begin
        cmp({e.tag, ".ldisp"}, LDISP, e.l);
        cmp({e.tag, ".rdisp"}, RDISP, e.r);
        cmp({e.tag, ".scl"}, SC_LDISP, e.sl);
        cmp({e.tag, ".scr"}, SC_RDISP, e.sr);
        cmp({e.tag, ".over"}, {12'd0, GAME_OVER}, {12'd0, e.over});
        cmp({e.tag, ".state"}, {11'd0, dut.state_r}, {11'd0, e.st});
      end
    end
  endtask

  // Both players strobe together; returns just after the evaluation edge.
  task automatic play(input logic [1:0] a, input logic [1:0] b);
    A_VALID = 1'b1; A_SIGN = a; B_VALID = 1'b1; B_SIGN = b;
    tick();
    A_VALID = 1'b0; B_VALID = 1'b0;
    tick();
  endtask

  task automatic do_reset();
    RST = 1'b1;
    tick();
    RST = 1'b0;
  endtask

  initial begin
    // Reset state
    tick();
    do_reset();
    expect_out("reset", 1'b0, E_ZERO, E_ZERO, E_D0, E_D0, 1'b0, ST_NEUTRAL);
    check_out();

    // Rock beats scissors from neutral, then a tie scores for the attacker
    expect_out("r1_rock_sci", 1'b0, E_ROCK, E_SCI, E_D0, E_D0, 1'b0, ST_A_ATK);
    play(R, S); check_out();
    expect_out("r2_tie_score", 1'b0, E_ROCK, E_ROCK, E_D1, E_D0, 1'b0, ST_NEUTRAL);
    play(R, R); check_out();

    // Staggered strobes with an ignored extra A strobe
    A_VALID = 1'b1; A_SIGN = P; tick();
    A_VALID = 1'b0; tick();
    A_VALID = 1'b1; A_SIGN = S; tick();
    A_VALID = 1'b0; B_VALID = 1'b1; B_SIGN = R; tick();
    B_VALID = 1'b0;
    expect_out("stagger_pre", 1'b0, E_ROCK, E_ROCK, E_D1, E_D0, 1'b0, ST_NEUTRAL);
    check_out();
    tick();
    expect_out("stagger_eval", 1'b0, E_PAP, E_ROCK, E_D1, E_D0, 1'b0, ST_A_ATK);
    check_out();

    // Void round with an invalid sign
    do_reset();
    expect_out("void", 1'b0, E_INV, E_PAP, E_D0, E_D0, 1'b0, ST_NEUTRAL);
    play(X, P); check_out();
    cmp("void.round", {9'd0, dut.round_r}, 13'd0);

    // B reaches the winning score
    do_reset();
    expect_out("b1", 1'b0, E_SCI, E_ROCK, E_D0, E_D0, 1'b0, ST_B_ATK);
    play(S, R); check_out();
    expect_out("b2", 1'b0, E_PAP, E_PAP, E_D0, E_D1, 1'b0, ST_NEUTRAL);
    play(P, P); check_out();
    expect_out("b3", 1'b0, E_PAP, E_SCI, E_D0, E_D1, 1'b0, ST_B_ATK);
    play(P, S); check_out();
    expect_out("b4", 1'b0, E_ROCK, E_ROCK, E_D0, E_D2, 1'b0, ST_NEUTRAL);
    play(R, R); check_out();
    expect_out("b5", 1'b0, E_ROCK, E_PAP, E_D0, E_D2, 1'b0, ST_B_ATK);
    play(R, P); check_out();
    expect_out("b_win", 1'b0, E_BW_L, E_BW_R, E_D0, E_D3, 1'b1, ST_OVER);
    play(S, S); check_out();
    expect_out("over_hold", 1'b0, E_BW_L, E_BW_R, E_D0, E_D3, 1'b1, ST_OVER);
    play(R, S); check_out();

    // Round budget of two on the second instance; void rounds do not count
    do_reset();
    expect_out("mr_tie1", 1'b1, E_ROCK, E_ROCK, E_D0, E_D0, 1'b0, ST_NEUTRAL);
    play(R, R); check_out();
    expect_out("mr_void", 1'b1, E_INV, E_ROCK, E_D0, E_D0, 1'b0, ST_NEUTRAL);
    play(X, R); check_out();
    expect_out("mr_draw", 1'b1, E_DRAW, E_DRAW, E_D0, E_D0, 1'b1, ST_OVER);
    play(P, P); check_out();

    // Reach 2:1, leave a partial capture pending, then reset
    do_reset();
    expect_out("rst_reset_from_over", 1'b1, E_ZERO, E_ZERO, E_D0, E_D0, 1'b0, ST_NEUTRAL);
    check_out();
    play(R, S); play(R, R); play(S, R); play(P, P); play(P, R);
    expect_out("score_2_1", 1'b0, E_SCI, E_SCI, E_D2, E_D1, 1'b0, ST_NEUTRAL);
    play(S, S); check_out();
    A_VALID = 1'b1; A_SIGN = R; tick();
    A_VALID = 1'b0;
    do_reset();
    expect_out("rst_pending", 1'b0, E_ZERO, E_ZERO, E_D0, E_D0, 1'b0, ST_NEUTRAL);
    check_out();
    B_VALID = 1'b1; B_SIGN = P; tick();
    B_VALID = 1'b0; tick(); tick();
    expect_out("b_only_no_eval", 1'b0, E_ZERO, E_ZERO, E_D0, E_D0, 1'b0, ST_NEUTRAL);
    check_out();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
